regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file between several writeback requesters (e.g. ALU and load unit) with round-robin arbitration and valid/ready handshakes. Also keeps a per-register busy scoreboard: issue logic reserves a destination, and the bit clears when the write to that register commits. The block sits between the writeback sources and the register file's writeReg/writeData/writeEnable inputs.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 tb/tb_regfile_write_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants, reused by the write arbiter, the register file and issue logic.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: scans from the pointer, grants the first requester (one-hot),
// then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] request_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d, idx;
  logic            found;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PtrW'((32'(ptr_q) + k) % N);
      if (!found && request_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        ptr_d        = PtrW'((32'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among writeback sources and tracks per-register
// outstanding writes in a single-bit busy scoreboard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned REG_ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int unsigned DATA_W     = regfile_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] reqReg,
  input  logic [NUM_REQ*DATA_W-1:0]     reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  input  logic                          reserveValid,
  input  logic [REG_ADDR_W-1:0]         reserveReg,
  output logic [REG_ADDR_W-1:0]         writeReg,
  output logic [DATA_W-1:0]             writeData,
  output logic                          writeEnable,
  output logic [NUM_REGS-1:0]           busy
);

  logic [NUM_REQ-1:0]    request, grant;
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0]     sel_data;
  logic                  accepted;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  // No grants while reset is held, so nothing is handshaken into a stage being cleared.
  assign request = reqValid & {NUM_REQ{~reset}};

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk_i     (clk),
    .reset_i   (reset),
    .request_i (request),
    .grant_o   (grant)
  );

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_reg  = reqReg[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = reqData[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accepted = |grant;

  always_comb begin
    we_d    = accepted && (sel_reg != REG_ADDR_W'(ZERO_REG));
    wreg_d  = accepted ? sel_reg : wreg_q;
    wdata_d = accepted ? sel_data : wdata_q;

    busy_d = busy_q;
    if (we_q) begin
      busy_d[wreg_q] = 1'b0;
    end
    // Applied after the clear: a new producer reserving the same register takes over.
    if (reserveValid && (reserveReg != REG_ADDR_W'(ZERO_REG))) begin
      busy_d[reserveReg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign reqReady    = grant;
  assign writeEnable = we_q;
  assign writeReg    = wreg_q;
  assign writeData   = wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: arbitration order, output stage, scoreboard, reset.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  reqValid;
  logic [9:0]  reqReg;
  logic [63:0] reqData;
  logic [1:0]  reqReady;
  logic        reserveValid;
  logic [4:0]  reserveReg;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(
    .NUM_REQ    (2),
    .REG_ADDR_W (5),
    .DATA_W     (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .reqValid     (reqValid),
    .reqReg       (reqReg),
    .reqData      (reqData),
    .reqReady     (reqReady),
    .reserveValid (reserveValid),
    .reserveReg   (reserveReg),
    .writeReg     (writeReg),
    .writeData    (writeData),
    .writeEnable  (writeEnable),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_g  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [4:0]  exp_r  [4] = '{5'd3, 5'd7, 5'd3, 5'd7};
  logic [31:0] exp_d  [4] = '{32'hAAAA0000, 32'h5555FFFF, 32'hAAAA0000, 32'h5555FFFF};

  initial begin
    reset        = 1'b1;
    reqValid     = 2'b00;
    reqReg       = '0;
    reqData      = '0;
    reserveValid = 1'b0;
    reserveReg   = '0;
    step();
    reqValid = 2'b11;
    #1;
    check("ready_in_reset", 32'(reqReady), 32'h0);
    step();
    check("rst_we", 32'(writeEnable), 32'h0);
    check("rst_wreg", 32'(writeReg), 32'h0);
    check("rst_wdata", writeData, 32'h0);
    check("rst_busy", busy, 32'h0);
    reset = 1'b0;

    // Alternating grants with both requesters valid
    reqReg  = {5'd7, 5'd3};
    reqData = {32'h5555FFFF, 32'hAAAA0000};
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_grant%0d", k), 32'(reqReady), 32'(exp_g[k]));
      if (k > 0) begin
        check($sformatf("rr_we%0d", k - 1), 32'(writeEnable), 32'h1);
        check($sformatf("rr_wreg%0d", k - 1), 32'(writeReg), 32'(exp_r[k-1]));
        check($sformatf("rr_wdata%0d", k - 1), writeData, exp_d[k-1]);
      end
      step();
    end
    reqValid = 2'b00;
    #1;
    check("rr_we3", 32'(writeEnable), 32'h1);
    check("rr_wreg3", 32'(writeReg), 32'd7);
    check("idle_ready", 32'(reqReady), 32'h0);
    step();
    check("idle_we", 32'(writeEnable), 32'h0);
    check("hold_wreg", 32'(writeReg), 32'd7);
    check("hold_wdata", writeData, 32'h5555FFFF);

    // Write to r0 is accepted but suppressed
    reqValid = 2'b10;
    reqReg   = {5'd0, 5'd0};
    reqData  = {32'hDEADBEEF, 32'h0};
    #1;
    check("r0_ready", 32'(reqReady), 32'h2);
    step();
    reqValid = 2'b00;
    check("r0_we", 32'(writeEnable), 32'h0);
    check("r0_busy", busy, 32'h0);

    // Reserve r9, then commit it
    reserveValid = 1'b1;
    reserveReg   = 5'd9;
    step();
    reserveValid = 1'b0;
    check("rsv9_busy", busy, 32'h0000_0200);
    reqValid = 2'b01;
    reqReg   = {5'd0, 5'd9};
    reqData  = {32'h0, 32'h12345678};
    #1;
    check("w9_ready", 32'(reqReady), 32'h1);
    step();
    reqValid = 2'b00;
    check("w9_we", 32'(writeEnable), 32'h1);
    check("w9_wreg", 32'(writeReg), 32'd9);
    check("w9_busy_during", busy, 32'h0000_0200);
    step();
    check("w9_busy_after", busy, 32'h0);

    // Reserve r0 is ignored
    reserveValid = 1'b1;
    reserveReg   = 5'd0;
    step();
    reserveValid = 1'b0;
    check("rsv0_busy", busy, 32'h0);

    // Commit to r5 collides with a new reserve of r5: set wins
    reserveValid = 1'b1;
    reserveReg   = 5'd5;
    step();
    reserveValid = 1'b0;
    check("rsv5_busy", busy, 32'h0000_0020);
    reqValid = 2'b10;
    reqReg   = {5'd5, 5'd0};
    reqData  = {32'h0BADF00D, 32'h0};
    #1;
    check("w5_ready", 32'(reqReady), 32'h2);
    step();
    reqValid     = 2'b00;
    reserveValid = 1'b1;
    reserveReg   = 5'd5;
    check("w5_we", 32'(writeEnable), 32'h1);
    check("w5_wdata", writeData, 32'h0BADF00D);
    step();
    reserveValid = 1'b0;
    check("w5_setwins", busy, 32'h0000_0020);
    step();
    check("w5_still", busy, 32'h0000_0020);
    // A single further commit clears it (no counting)
    reqValid = 2'b01;
    reqReg   = {5'd0, 5'd5};
    step();
    reqValid = 2'b00;
    step();
    check("w5_cleared", busy, 32'h0);

    // Reset while a write to r12 is being driven
    reserveValid = 1'b1;
    reserveReg   = 5'd20;
    step();
    reserveReg = 5'd12;
    step();
    reserveValid = 1'b0;
    check("rsv12_busy", busy, 32'h0010_1000);
    reqValid = 2'b01;
    reqReg   = {5'd12, 5'd12};
    reqData  = {32'h11111111, 32'hC0FFEE00};
    #1;
    check("w12_ready", 32'(reqReady), 32'h1);
    step();
    reqValid = 2'b11;
    reset    = 1'b1;
    #1;
    check("w12_we", 32'(writeEnable), 32'h1);
    check("rst2_ready", 32'(reqReady), 32'h0);
    step();
    reset = 1'b0;
    #1;
    check("rst2_we", 32'(writeEnable), 32'h0);
    check("rst2_busy", busy, 32'h0);
    check("rst2_ptr", 32'(reqReady), 32'h1);
    step();
    reqValid = 2'b00;
    check("post_we", 32'(writeEnable), 32'h1);
    check("post_wdata", writeData, 32'hC0FFEE00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
